// File: rtl/mem_arbiter3_if.sv
// mem_arbiter3_if: bundles the three core request ports, the per-core
// completion/read-data returns and the shared single-port RAM port.
//   slave  modport : arbiter side (takes core requests and RAMq, drives
//                    acq, Dq, RAMAddress, RAMDin, RAMwren, stall_cnt)
//   master modport : environment side (cores + RAM model)
// Parameters AW/DW must match the arbiter instance parameters.
interface mem_arbiter3_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic [2:0]       rden;
   logic [2:0]       wren;
   logic [3*AW-1:0]  Address;
   logic [3*DW-1:0]  Din;
   logic [DW-1:0]    RAMq;
   logic [2:0]       acq;
   logic [3*DW-1:0]  Dq;
   logic [AW-1:0]    RAMAddress;
   logic [DW-1:0]    RAMDin;
   logic             RAMwren;
   logic [31:0]      stall_cnt;

   modport slave (
      input  rden, wren, Address, Din, RAMq,
      output acq, Dq, RAMAddress, RAMDin, RAMwren, stall_cnt
   );

   modport master (
      output rden, wren, Address, Din, RAMq,
      input  acq, Dq, RAMAddress, RAMDin, RAMwren, stall_cnt
   );
endinterface

// File: rtl/mem_arbiter3.sv
// mem_arbiter3: three-port round-robin arbiter in front of one shared
// single-port synchronous RAM. Serialises core reads/writes, returns read
// data per core and pulses acq[i] for one cycle when core i's access is done.
//
// Ports:
//   CLK    system clock (RAM shares it)
//   rst_n  asynchronous active-low reset
//   bus    mem_arbiter3_if.slave: rden/wren/Address/Din/RAMq in,
//          acq/Dq/RAMAddress/RAMDin/RAMwren/stall_cnt out
//
// Optional feature: define MEMARB_STALL_CNT_EN to build the saturating
// contention counter on stall_cnt; otherwise stall_cnt is tied to zero.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no access in flight; pick round-robin winner, launch RAM cmd
// S_ACCESS | RAM samples addr/data/wren at the end of this cycle
// S_WAIT   | read latency countdown; capture RAMq into Dq[sel] at zero
// S_DONE   | acq[sel] pulses for this single cycle
module mem_arbiter3 #(
   parameter int AW     = 8,
   parameter int DW     = 8,
   parameter int RD_LAT = 1
) (
   input  logic               CLK,
   input  logic               rst_n,
   mem_arbiter3_if.slave      bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WAIT   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [1:0]       r_sel;
   logic [1:0]       r_last;
   logic [1:0]       r_lat_cnt;
   logic [AW-1:0]    r_ram_addr;
   logic [DW-1:0]    r_ram_din;
   logic             r_ram_wren;
   logic [3*DW-1:0]  r_dq;

   logic [2:0]       w_req;
   logic [1:0]       w_cand1;
   logic [1:0]       w_cand2;
   logic [1:0]       w_winner;
   logic [2:0]       w_acq;

   function automatic logic [1:0] inc_mod3(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   assign w_req = bus.rden | bus.wren;

   // Search last+1, last+2, then last itself.
   always_comb begin
      w_cand1  = inc_mod3(r_last);
      w_cand2  = inc_mod3(w_cand1);
      w_winner = r_last;
      if (w_req[w_cand1])
         w_winner = w_cand1;
      else if (w_req[w_cand2])
         w_winner = w_cand2;
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_acq        = 3'b000;
      unique case (r_state)
         S_IDLE: begin
            if (|w_req)
               w_next_state = S_ACCESS;
         end
         S_ACCESS: begin
            // The registered write enable still tells us the access type.
            w_next_state = r_ram_wren ? S_DONE : S_WAIT;
         end
         S_WAIT: begin
            if (r_lat_cnt == 2'd0)
               w_next_state = S_DONE;
         end
         S_DONE: begin
            w_acq        = 3'b001 << r_sel;
            w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_sel      <= 2'd0;
         r_last     <= 2'd2;
         r_lat_cnt  <= 2'd0;
         r_ram_addr <= '0;
         r_ram_din  <= '0;
         r_ram_wren <= 1'b0;
         r_dq       <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (|w_req) begin
                  r_sel      <= w_winner;
                  r_last     <= w_winner;
                  r_ram_addr <= bus.Address[w_winner*AW +: AW];
                  r_ram_din  <= bus.Din[w_winner*DW +: DW];
                  // wren wins over rden when both are set.
                  r_ram_wren <= bus.wren[w_winner];
               end else begin
                  r_ram_wren <= 1'b0;
               end
            end
            S_ACCESS: begin
               r_ram_wren <= 1'b0;
               r_lat_cnt  <= LAT_INIT;
            end
            S_WAIT: begin
               if (r_lat_cnt == 2'd0)
                  r_dq[r_sel*DW +: DW] <= bus.RAMq;
               else
                  r_lat_cnt <= r_lat_cnt - 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.acq        = w_acq;
   assign bus.Dq         = r_dq;
   assign bus.RAMAddress = r_ram_addr;
   assign bus.RAMDin     = r_ram_din;
   assign bus.RAMwren    = r_ram_wren;

`ifdef MEMARB_STALL_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [1:0]  w_holder;
   logic        w_stall;

   // In IDLE the bus "holder" is this cycle's winner; otherwise it is sel.
   always_comb begin
      w_holder = (r_state == S_IDLE) ? w_winner : r_sel;
      w_stall  = |(w_req & ~(3'b001 << w_holder));
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n)
         r_stall_cnt <= 32'd0;
      else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
         r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign bus.stall_cnt = r_stall_cnt;
`else
   assign bus.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_arbiter3.sv
// tb_mem_arbiter3: directed self-checking bench for mem_arbiter3 with a
// behavioural single-port RAM (read latency 1, read-before-write).
module tb_mem_arbiter3;
   localparam int AW = 8;
   localparam int DW = 8;

   logic CLK   = 1'b0;
   logic rst_n = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   mem_arbiter3_if #(.AW(AW), .DW(DW)) bus ();

   mem_arbiter3 #(.AW(AW), .DW(DW), .RD_LAT(1)) dut (
      .CLK   (CLK),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   logic [7:0] ram [0:255];

   always @(posedge CLK) begin
      if (!rst_n)
         ram[8'h10] <= 8'hA5;
      else if (bus.RAMwren)
         ram[bus.RAMAddress] <= bus.RAMDin;
      bus.RAMq <= ram[bus.RAMAddress];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clk1();
      @(posedge CLK);
      #1;
   endtask

   // Launch one access on a single port at cycle 0 and run until acq.
   task automatic run_access(input int port, input logic rd, input logic wr,
                             input logic [7:0] addr, input logic [7:0] din,
                             output int acq_cyc, output logic [2:0] acq_val,
                             output logic [2:0] acq_after, output int wren_cycles,
                             output logic [7:0] w_addr, output logic [7:0] w_din,
                             output logic [7:0] addr_c1);
      bus.rden    = 3'(rd) << port;
      bus.wren    = 3'(wr) << port;
      bus.Address = '0;
      bus.Din     = '0;
      bus.Address[port*AW +: AW] = addr;
      bus.Din[port*DW +: DW]     = din;
      acq_cyc     = -1;
      acq_val     = 3'b000;
      wren_cycles = 0;
      w_addr      = 8'h00;
      w_din       = 8'h00;
      addr_c1     = 8'h00;
      for (int c = 0; c < 20; c++) begin
         if (c == 1) addr_c1 = bus.RAMAddress;
         if (bus.RAMwren) begin
            wren_cycles++;
            w_addr = bus.RAMAddress;
            w_din  = bus.RAMDin;
         end
         if (bus.acq != 3'b000) begin
            acq_cyc = c;
            acq_val = bus.acq;
            break;
         end
         clk1();
      end
      bus.rden = 3'b000;
      bus.wren = 3'b000;
      clk1();
      acq_after = bus.acq;
      if (bus.RAMwren) wren_cycles++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clk1();
      clk1();
      rst_n = 1'b1;
      clk1();
   endtask

   int         acq_cyc, wren_cycles;
   logic [2:0] acq_val, acq_after;
   logic [7:0] w_addr, w_din, addr_c1;

   initial begin
      bus.rden    = 3'b000;
      bus.wren    = 3'b000;
      bus.Address = '0;
      bus.Din     = '0;

      // Reset state
      clk1();
      clk1();
      chk("rst_acq",   32'(bus.acq), 32'h0);
      chk("rst_dq",    32'(bus.Dq), 32'h0);
      chk("rst_raddr", 32'(bus.RAMAddress), 32'h0);
      chk("rst_rdin",  32'(bus.RAMDin), 32'h0);
      chk("rst_rwren", 32'(bus.RAMwren), 32'h0);
      chk("rst_stall", bus.stall_cnt, 32'h0);
      rst_n = 1'b1;
      clk1();

      // Core 1 reads 0x10
      run_access(1, 1'b1, 1'b0, 8'h10, 8'h00, acq_cyc, acq_val, acq_after, wren_cycles, w_addr, w_din, addr_c1);
      chk("rd1_addr_c1", 32'(addr_c1), 32'h10);
      chk("rd1_acq_cyc", 32'(acq_cyc), 32'd3);
      chk("rd1_acq_val", 32'(acq_val), 32'b010);
      chk("rd1_acq_one", 32'(acq_after), 32'b000);
      chk("rd1_dq1",     32'(bus.Dq[15:8]), 32'hA5);
      chk("rd1_dq0",     32'(bus.Dq[7:0]), 32'h00);
      chk("rd1_dq2",     32'(bus.Dq[23:16]), 32'h00);

      // Core 0 writes 0x3C to 0x05
      run_access(0, 1'b0, 1'b1, 8'h05, 8'h3C, acq_cyc, acq_val, acq_after, wren_cycles, w_addr, w_din, addr_c1);
      chk("wr0_wren_cnt", 32'(wren_cycles), 32'd1);
      chk("wr0_addr",     32'(w_addr), 32'h05);
      chk("wr0_din",      32'(w_din), 32'h3C);
      chk("wr0_acq_cyc",  32'(acq_cyc), 32'd2);
      chk("wr0_acq_val",  32'(acq_val), 32'b001);
      chk("wr0_acq_one",  32'(acq_after), 32'b000);

      // Core 2 reads back 0x05
      run_access(2, 1'b1, 1'b0, 8'h05, 8'h00, acq_cyc, acq_val, acq_after, wren_cycles, w_addr, w_din, addr_c1);
      chk("rd2_acq_cyc", 32'(acq_cyc), 32'd3);
      chk("rd2_acq_val", 32'(acq_val), 32'b100);
      chk("rd2_dq2",     32'(bus.Dq[23:16]), 32'h3C);
      chk("rd2_dq1",     32'(bus.Dq[15:8]), 32'hA5);
      chk("rd2_wren",    32'(wren_cycles), 32'd0);

      // Core 2 with rden and wren both high: write wins
      run_access(2, 1'b1, 1'b1, 8'h20, 8'h77, acq_cyc, acq_val, acq_after, wren_cycles, w_addr, w_din, addr_c1);
      chk("rw2_acq_cyc", 32'(acq_cyc), 32'd2);
      chk("rw2_acq_val", 32'(acq_val), 32'b100);
      chk("rw2_wren",    32'(wren_cycles), 32'd1);
      chk("rw2_din",     32'(w_din), 32'h77);
      chk("rw2_dq2",     32'(bus.Dq[23:16]), 32'h3C);

      run_access(0, 1'b1, 1'b0, 8'h20, 8'h00, acq_cyc, acq_val, acq_after, wren_cycles, w_addr, w_din, addr_c1);
      chk("rd0_acq_cyc", 32'(acq_cyc), 32'd3);
      chk("rd0_dq0",     32'(bus.Dq[7:0]), 32'h77);

      // Reset asserted during WAIT of a core-0 read
      bus.rden    = 3'b001;
      bus.Address = {8'h00, 8'h00, 8'h10};
      clk1();
      clk1();
      chk("mid_acq_pre", 32'(bus.acq), 32'h0);
      rst_n = 1'b0;
      #1;
      chk("mid_acq",   32'(bus.acq), 32'h0);
      chk("mid_dq",    32'(bus.Dq), 32'h0);
      chk("mid_raddr", 32'(bus.RAMAddress), 32'h0);
      chk("mid_rdin",  32'(bus.RAMDin), 32'h0);
      chk("mid_rwren", 32'(bus.RAMwren), 32'h0);
      chk("mid_stall", bus.stall_cnt, 32'h0);
      bus.rden = 3'b000;
      clk1();
      chk("mid_acq_hold", 32'(bus.acq), 32'h0);
      clk1();
      rst_n = 1'b1;
      clk1();
      run_access(1, 1'b1, 1'b0, 8'h10, 8'h00, acq_cyc, acq_val, acq_after, wren_cycles, w_addr, w_din, addr_c1);
      chk("post_acq_cyc", 32'(acq_cyc), 32'd3);
      chk("post_acq_val", 32'(acq_val), 32'b010);
      chk("post_dq1",     32'(bus.Dq[15:8]), 32'hA5);
      chk("post_dq0",     32'(bus.Dq[7:0]), 32'h00);

      // Cores 0 and 1 request together; each drops at its acq
      begin
         int c0 = -1;
         int c1 = -1;
         bus.rden    = 3'b011;
         bus.Address = {8'h00, 8'h05, 8'h10};
         for (int c = 0; c < 30; c++) begin
            if (bus.acq[0]) begin c0 = c; bus.rden[0] = 1'b0; end
            if (bus.acq[1]) begin c1 = c; bus.rden[1] = 1'b0; end
            if (c1 >= 0) break;
            clk1();
         end
         bus.rden = 3'b000;
         clk1();
         chk("pair_acq0_cyc", 32'(c0), 32'd3);
         chk("pair_acq1_cyc", 32'(c1), 32'd7);
         chk("pair_dq",       32'(bus.Dq[15:0]), 32'h3CA5);
`ifdef MEMARB_STALL_CNT_EN
         chk("pair_stall", bus.stall_cnt, 32'd4);
`else
         chk("pair_stall", bus.stall_cnt, 32'd0);
`endif
      end

      // All three request continuously from reset
      do_reset();
      begin
         int n_gr = 0;
         bus.rden    = 3'b111;
         bus.Address = {8'h20, 8'h05, 8'h10};
         for (int c = 0; c < 60; c++) begin
            if (bus.acq != 3'b000) begin
               chk($sformatf("rr_grant%0d", n_gr), 32'(bus.acq), 32'(3'b001 << (n_gr % 3)));
               chk($sformatf("rr_cyc%0d", n_gr), 32'(c), 32'(3 + 4*n_gr));
               n_gr++;
               if (n_gr == 6) bus.rden = 3'b000;
            end
            if (n_gr == 6) break;
            clk1();
         end
         clk1();
         chk("rr_count", 32'(n_gr), 32'd6);
         chk("rr_dq",    32'(bus.Dq), 32'h773CA5);
         chk("rr_idle",  32'(bus.acq), 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
